// File: rtl/sha_round_ctrl.sv
// Sequencing FSM for the SHA compression datapath: job start, block intake, round control, digest handoff.
// Latency: block accept to final_add is 65 cycles (SHA-256) / 81 cycles (SHA-512); pulses are registered.
// Backpressure: holds in WAIT_BLK until blk_valid and in DONE until digest_ready; abort overrides everything.
module sha_round_ctrl #(
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 blk_valid,
    input  logic                 blk_last,
    output logic                 blk_ready,
    input  logic                 round_last,
    output logic                 rnd_init,
    output logic                 rnd_mode,
    output logic                 round_en,
    output logic                 load_w,
    output logic                 hash_init,
    output logic                 final_add,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic                 ready,
    output logic                 err,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BLK = 3'd1;
    localparam logic [2:0] S_ROUND    = 3'd2;
    localparam logic [2:0] S_FINAL    = 3'd3;
    localparam logic [2:0] S_ADD      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       mode_q;
    logic       last_q;
    logic [6:0] wd;
    logic [6:0] wd_limit;
    logic       job_start;

    // Watchdog trips on the last cycle the counter could legally still reach round_last.
    assign wd_limit  = mode_q ? 7'd79 : 7'd63;
    assign job_start = (state == S_IDLE) && (state_nxt == S_WAIT_BLK);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start) state_nxt = S_WAIT_BLK;
                S_WAIT_BLK: if (blk_valid) state_nxt = S_ROUND;
                S_ROUND: begin
                    if (round_last)           state_nxt = S_FINAL;
                    else if (wd == wd_limit)  state_nxt = S_ERR;
                end
                S_FINAL:    state_nxt = S_ADD;
                S_ADD:      state_nxt = last_q ? S_DONE : S_WAIT_BLK;
                S_DONE:     if (digest_ready) state_nxt = S_IDLE;
                S_ERR:      state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            last_q    <= 1'b0;
            wd        <= 7'd0;
            hash_init <= 1'b0;
            load_w    <= 1'b0;
            final_add <= 1'b0;
            err       <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            // Pulses key off the taken transition, so an abort suppresses them automatically.
            hash_init <= job_start;
            load_w    <= (state == S_WAIT_BLK) && (state_nxt == S_ROUND);
            final_add <= (state == S_FINAL) && (state_nxt == S_ADD);
            wd        <= (state == S_ROUND) ? wd + 7'd1 : 7'd0;
            if (job_start) begin
                mode_q  <= mode;
                blk_cnt <= '0;
            end
            if ((state == S_WAIT_BLK) && (state_nxt == S_ROUND))
                last_q <= blk_last;
            if ((state == S_ADD) && !abort && (blk_cnt != '1))
                blk_cnt <= blk_cnt + 1'b1;
            if (state_nxt == S_ERR)
                err <= 1'b1;
            else if (job_start)
                err <= 1'b0;
        end
    end

    assign ready        = (state == S_IDLE);
    assign blk_ready    = (state == S_WAIT_BLK);
    assign round_en     = (state == S_ROUND) || (state == S_FINAL);
    assign rnd_init     = !round_en;
    assign digest_valid = (state == S_DONE);
    assign rnd_mode     = mode_q;

endmodule
